cnn_conv_engine: RTL

- Parametrised successor to the single-shot CNN core.
- Accepts a multi-channel image over a valid/ready pixel stream into local frame memory, with a KxK kernel per channel preloaded through a write port.
- Computes a stride-1, valid-padding 2D convolution, summing across channels, with optional ReLU.
- Streams results in raster order over a valid/ready output with backpressure, then pulses done; sits between the input buffer and the classifier stage.

---
 rtl/cnn_conv_engine_if.sv | 24 ++
 rtl/cnn_conv_engine.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cnn_conv_engine_if.sv
// Pixel-in / result-out stream bundle for cnn_conv_engine.
// master = upstream/downstream side, slave = engine side.
interface cnn_conv_engine_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32
);
  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] pix_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              out_last;

  modport master (
    output pix_valid, pix_data, out_ready,
    input  pix_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  pix_valid, pix_data, out_ready,
    output pix_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/cnn_conv_engine.sv
// Multi-channel KxK valid-padding convolution engine, one MAC per cycle.
// Frame is buffered locally, results stream out in raster order.
module cnn_conv_engine #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int CH     = 1,
  parameter int RELU   = 1,
  localparam int NTAP  = CH*K*K,
  localparam int WA_W  = (NTAP > 1) ? $clog2(NTAP) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wgt_we,
  input  logic [WA_W-1:0]   wgt_addr,
  input  logic [DATA_W-1:0] wgt_data,
  output logic              busy,
  output logic              done,
  cnn_conv_engine_if.slave  bus
);
  localparam int OW   = IMG_W - K + 1;
  localparam int OH   = IMG_H - K + 1;
  localparam int NPIX = CH*IMG_W*IMG_H;
  localparam int PA_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int XB   = (OW > 1) ? $clog2(OW) : 1;
  localparam int YB   = (OH > 1) ? $clog2(OH) : 1;
  localparam int KB   = (K > 1) ? $clog2(K) : 1;
  localparam int CB   = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, COMPUTE, OUT, DONE
  } state_t;

  state_t state, nxt;

  logic [DATA_W-1:0] img [NPIX];
  logic [DATA_W-1:0] wgt [NTAP];

  logic [PA_W-1:0] pcnt;
  logic [XB-1:0]   ox;
  logic [YB-1:0]   oy;
  logic [KB-1:0]   kx;
  logic [KB-1:0]   ky;
  logic [CB-1:0]   kc;
  logic [WA_W-1:0] tap;
  logic [ACC_W-1:0] acc;

  logic                       pix_hs;
  logic                       load_last;
  logic                       tap_last;
  logic                       is_last;
  logic [PA_W-1:0]            pix_idx;
  logic signed [DATA_W-1:0]   img_q;
  logic signed [DATA_W-1:0]   wgt_q;
  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]           prod_a;
  logic [ACC_W-1:0]           acc_fin;

  assign pix_hs    = bus.pix_valid && (state == LOAD);
  assign load_last = pcnt == PA_W'(NPIX-1);
  assign tap_last  = tap == WA_W'(NTAP-1);
  assign is_last   = (ox == XB'(OW-1)) && (oy == YB'(OH-1));

  // Flat frame address of pixel[c][oy+ky][ox+kx].
  always_comb begin
    pix_idx = PA_W'(int'(kc) * (IMG_W*IMG_H)
            + (int'(oy) + int'(ky)) * IMG_W
            + int'(ox) + int'(kx));
  end

  assign img_q = img[pix_idx];
  assign wgt_q = wgt[tap];
  assign prod  = img_q * wgt_q;
  // Signed size cast truncates or sign-extends as ACC_W demands.
  assign prod_a  = ACC_W'(prod);
  assign acc_fin = (tap == '0) ? prod_a : acc + prod_a;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = LOAD;
      LOAD:    if (pix_hs && load_last) nxt = COMPUTE;
      COMPUTE: if (tap_last) nxt = OUT;
      OUT:     if (bus.out_ready) nxt = is_last ? DONE : COMPUTE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.pix_ready = state == LOAD;
    bus.out_valid = state == OUT;
    bus.out_last  = (state == OUT) && is_last;
    busy          = state != IDLE;
    done          = state == DONE;
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && wgt_we) wgt[wgt_addr] <= wgt_data;
  end

  always_ff @(posedge clk) begin
    if (pix_hs) img[pcnt] <= bus.pix_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pcnt         <= '0;
      ox           <= '0;
      oy           <= '0;
      kx           <= '0;
      ky           <= '0;
      kc           <= '0;
      tap          <= '0;
      acc          <= '0;
      bus.out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) pcnt <= '0;
        end
        LOAD: begin
          if (pix_hs) begin
            pcnt <= pcnt + PA_W'(1);
            if (load_last) begin
              ox  <= '0;
              oy  <= '0;
              kx  <= '0;
              ky  <= '0;
              kc  <= '0;
              tap <= '0;
            end
          end
        end
        COMPUTE: begin
          acc <= acc_fin;
          if (tap_last) begin
            if (RELU != 0 && acc_fin[ACC_W-1]) bus.out_data <= '0;
            else                               bus.out_data <= acc_fin;
            tap <= '0;
            kx  <= '0;
            ky  <= '0;
            kc  <= '0;
          end else begin
            tap <= tap + WA_W'(1);
            if (kx == KB'(K-1)) begin
              kx <= '0;
              if (ky == KB'(K-1)) begin
                ky <= '0;
                kc <= kc + CB'(1);
              end else begin
                ky <= ky + KB'(1);
              end
            end else begin
              kx <= kx + KB'(1);
            end
          end
        end
        OUT: begin
          if (bus.out_ready && !is_last) begin
            if (ox == XB'(OW-1)) begin
              ox <= '0;
              oy <= oy + YB'(1);
            end else begin
              ox <= ox + XB'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
